// File: rtl/dmem_bridge.sv
// dmem_bridge: connects a core's data-memory port to a simple request/response bus.
// The core stalls while an access is outstanding. Misaligned addresses and bus
// timeouts finish through a one-cycle error state.
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        err_sticky,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic        bus_ready,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  // The counter is at least 8 bits wide, and wide enough to hold TIMEOUT_CYCLES.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             bus_req_reg;
  logic [31:0]      bus_addr_reg;
  logic [31:0]      bus_wdata_reg;
  logic             bus_we_reg;
  logic [31:0]      rdata_reg;
  logic             err_sticky_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout_hit;

  // Timeout fires in the cycle whose count increment would reach the limit.
  // This bounds the time spent in REQ plus WAIT to TIMEOUT_CYCLES cycles.
  assign cnt_inc     = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_hit = (cnt_inc >= TIMEOUT_LIM);

  assign bus_req    = bus_req_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_wdata  = bus_wdata_reg;
  assign bus_we     = bus_we_reg;
  assign cpu_rdata  = rdata_reg;
  assign err_sticky = err_sticky_reg;
  assign cpu_err    = (state_reg == ERR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and stall decode.
  // In WAIT, a response that arrives in the same cycle as the timeout still completes the access.
  always_comb begin
    state_next = state_reg;
    cpu_stall  = 1'b0;
    case (state_reg)
      IDLE: begin
        cpu_stall = cpu_req;
        if (cpu_req) begin
          state_next = (cpu_addr[1:0] == 2'b00) ? REQ : ERR;
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
        if (timeout_hit) begin
          state_next = ERR;
        end else if (bus_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (bus_resp_valid) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus request registers, timeout counter, load data and error latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req_reg    <= 1'b0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      bus_we_reg     <= 1'b0;
      rdata_reg      <= '0;
      err_sticky_reg <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      // bus_req is high exactly while the FSM sits in REQ.
      bus_req_reg <= (state_next == REQ);

      // Request fields are captured once and then held until the next access starts.
      if (state_reg == IDLE && state_next == REQ) begin
        bus_addr_reg  <= cpu_addr;
        bus_wdata_reg <= cpu_wdata;
        bus_we_reg    <= cpu_we;
      end

      if (state_reg != REQ && state_next == REQ) begin
        cnt_reg <= '0;
      end else if ((state_reg == REQ || state_reg == WAIT) && cnt_reg != '1) begin
        cnt_reg <= cnt_inc[CNT_W-1:0];
      end

      if (state_reg == WAIT && state_next == DONE && !bus_we_reg) begin
        rdata_reg <= bus_rdata;
      end

      // The error cycle presents zero load data and leaves the sticky flag set.
      if (state_next == ERR) begin
        rdata_reg      <= '0;
        err_sticky_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge. Each completion (a stall high-to-low transition)
// is checked against a scoreboard entry that the stimulus pushed in advance.
module tb_dmem_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        err_sticky;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_ready;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_we         (cpu_we),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .cpu_err        (cpu_err),
    .err_sticky     (err_sticky),
    .bus_req        (bus_req),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_we         (bus_we),
    .bus_ready      (bus_ready),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    logic        sticky;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;
  int   busreq_cnt = 0;
  logic prev_stall = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input string name, input logic err, input logic [31:0] rdata,
                              input logic sticky);
    exp_t e;
    e.name   = name;
    e.err    = err;
    e.rdata  = rdata;
    e.sticky = sticky;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Per-cycle counters for stall and bus_req, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_stall === 1'b1) stall_cnt++;
      if (bus_req === 1'b1) busreq_cnt++;
    end
  end

  // Completion monitor: every stall high-to-low transition pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && prev_stall && cpu_stall === 1'b0) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_completion: got err=%0b rdata=%08h, required no completion",
                   cpu_err, cpu_rdata);
        end else begin
          e = sb.pop_front();
          if (cpu_err !== e.err || cpu_rdata !== e.rdata || err_sticky !== e.sticky) begin
            n_bad++;
            $display("FAIL %s: got err=%0b rdata=%08h sticky=%0b, required err=%0b rdata=%08h sticky=%0b",
                     e.name, cpu_err, cpu_rdata, err_sticky, e.err, e.rdata, e.sticky);
          end else begin
            $display("ok   %s: err=%0b rdata=%08h sticky=%0b", e.name, cpu_err, cpu_rdata, err_sticky);
          end
        end
      end
      prev_stall = (cpu_stall === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic got;
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    bus_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;

    // Reset state.
    tick(); tick();
    @(negedge clk); #1;
    chk("rst_bus_req",    32'(bus_req),    32'h0);
    chk("rst_bus_addr",   bus_addr,        32'h0);
    chk("rst_bus_wdata",  bus_wdata,       32'h0);
    chk("rst_bus_we",     32'(bus_we),     32'h0);
    chk("rst_cpu_rdata",  cpu_rdata,       32'h0);
    chk("rst_cpu_err",    32'(cpu_err),    32'h0);
    chk("rst_err_sticky", 32'(err_sticky), 32'h0);
    chk("rst_cpu_stall",  32'(cpu_stall),  32'h0);
    tick();
    reset = 1'b0;

    // Load with immediate bus_ready and a response one cycle later.
    cpu_req = 1'b1; cpu_addr = 32'h100; cpu_we = 1'b0; bus_ready = 1'b1;
    stall_cnt = 0;
    sb.push_back(mk("load", 1'b0, 32'hCAFEBABE, 1'b0));
    tick();
    @(negedge clk); #1;
    chk("load_bus_req", 32'(bus_req), 32'h1);
    tick();
    bus_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'hCAFEBABE;
    tick();
    bus_resp_valid = 1'b0; cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("load_stall_cycles", 32'(stall_cnt), 32'd3);

    // Store with bus_ready arriving in the fifth REQ cycle. A response carrying data must leave cpu_rdata unchanged.
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h204; cpu_wdata = 32'h12345678; cpu_we = 1'b1;
    stall_cnt = 0; busreq_cnt = 0;
    sb.push_back(mk("store", 1'b0, 32'hCAFEBABE, 1'b0));
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) bus_ready = 1'b1;
      @(negedge clk); #1;
      chk($sformatf("store_addr_req%0d", i),  bus_addr,      32'h204);
      chk($sformatf("store_wdata_req%0d", i), bus_wdata,     32'h12345678);
      chk($sformatf("store_we_req%0d", i),    32'(bus_we),   32'h1);
      tick();
    end
    bus_ready = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk); #1;
    chk("store_addr_wait", bus_addr, 32'h204);
    tick();
    bus_resp_valid = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk); #1;
    chk("store_bus_req_cycles", 32'(busreq_cnt), 32'd5);
    chk("store_stall_cycles",   32'(stall_cnt),  32'd7);

    // Misaligned address.
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h103; cpu_we = 1'b0;
    busreq_cnt = 0;
    sb.push_back(mk("misaligned", 1'b1, 32'h0, 1'b1));
    tick();
    cpu_req = 1'b0;
    tick();
    @(negedge clk); #1;
    chk("misaligned_err_pulse_end", 32'(cpu_err),    32'h0);
    chk("misaligned_sticky_held",   32'(err_sticky), 32'h1);
    chk("misaligned_rdata",         cpu_rdata,       32'h0);
    chk("misaligned_no_bus_req",    32'(busreq_cnt), 32'h0);

    // Timeout: bus accepts but never responds; ERR is expected 8 cycles after entering REQ.
    cpu_req = 1'b1; cpu_addr = 32'h300; bus_ready = 1'b1;
    sb.push_back(mk("timeout", 1'b1, 32'h0, 1'b1));
    tick();
    n = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      n++;
      @(negedge clk);
      if (cpu_err === 1'b1) got = 1'b1;
    end
    #1;
    chk("timeout_cycles", 32'(n), 32'd8);
    chk("timeout_bus_req", 32'(bus_req), 32'h0);
    chk("timeout_stall",   32'(cpu_stall), 32'h0);
    cpu_req = 1'b0; bus_ready = 1'b0;

    // Reset while in WAIT, followed by a late response.
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h100; bus_ready = 1'b1;
    sb.push_back(mk("reset_in_wait", 1'b0, 32'h0, 1'b0));
    tick();
    tick();
    bus_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; cpu_req = 1'b0; bus_resp_valid = 1'b1; bus_rdata = 32'h55AA55AA;
    @(negedge clk); #1;
    chk("reset_wait_bus_req", 32'(bus_req), 32'h0);
    tick();
    bus_resp_valid = 1'b0;
    @(negedge clk); #1;
    chk("reset_wait_rdata", cpu_rdata,       32'h0);
    chk("reset_wait_stall", 32'(cpu_stall),  32'h0);
    chk("reset_wait_err",   32'(cpu_err),    32'h0);

    // Back-to-back loads with cpu_req held high. In the second access, ready and response arrive together in REQ.
    tick();
    cpu_req = 1'b1; cpu_addr = 32'h400; cpu_we = 1'b0; bus_ready = 1'b1;
    sb.push_back(mk("b2b_first",  1'b0, 32'h11111111, 1'b0));
    sb.push_back(mk("b2b_second", 1'b0, 32'h22222222, 1'b0));
    tick();
    tick();
    bus_resp_valid = 1'b1; bus_rdata = 32'h11111111;
    tick();
    bus_resp_valid = 1'b0; cpu_addr = 32'h404;
    @(negedge clk); #1;
    chk("b2b_done_stall", 32'(cpu_stall), 32'h0);
    tick();
    @(negedge clk); #1;
    chk("b2b_second_idle_stall", 32'(cpu_stall), 32'h1);
    chk("b2b_second_idle_bus_req", 32'(bus_req), 32'h0);
    tick();
    bus_resp_valid = 1'b1; bus_rdata = 32'hBADBAD00;
    @(negedge clk); #1;
    chk("b2b_second_bus_req",  32'(bus_req), 32'h1);
    chk("b2b_second_bus_addr", bus_addr,     32'h404);
    tick();
    bus_resp_valid = 1'b1; bus_rdata = 32'h22222222; bus_ready = 1'b0;
    tick();
    bus_resp_valid = 1'b0; cpu_req = 1'b0;
    @(negedge clk); #1;
    chk("b2b_second_done_stall", 32'(cpu_stall), 32'h0);

    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles in REQ plus WAIT before a request aborts.
REQ-002 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port cpu_req, input, 1: core requests a data-memory access.
REQ-005 Port cpu_addr, input, 32: byte address, word access only.
REQ-006 Port cpu_wdata, input, 32: store data.
REQ-007 Port cpu_we, input, 1: 1 means store, 0 means load.
REQ-008 Port cpu_rdata, output, 32: load data; valid in the cycle cpu_stall is low after a request.
REQ-009 Port cpu_stall, output, 1: core holds all pipeline enables and request inputs while this is high.
REQ-010 Port cpu_err, output, 1: one-cycle pulse when a request completes abnormally.
REQ-011 Port err_sticky, output, 1: latched error; high after any cpu_err until reset.
REQ-012 Ports bus_req (output, 1), bus_addr (output, 32), bus_wdata (output, 32), bus_we (output, 1): registered bus request.
REQ-013 Ports bus_ready (input, 1), bus_resp_valid (input, 1), bus_rdata (input, 32): bus accept, response strobe and load data.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ, WAIT, DONE and ERR, encoded as a registered state.
REQ-015 In IDLE with cpu_req=1 and cpu_addr[1:0]=0, the block SHALL latch addr, wdata and we into the bus registers and go to REQ.
REQ-016 In IDLE with cpu_req=1 and cpu_addr[1:0]!=0, the block SHALL go to ERR with no bus activity.
REQ-017 In REQ, bus_req SHALL be 1; when bus_ready=1 the block SHALL go to WAIT, and bus_req SHALL drop on that edge.
REQ-018 In WAIT, when bus_resp_valid=1 the block SHALL capture bus_rdata into cpu_rdata (loads only) and go to DONE.
- A store completes on bus_resp_valid; cpu_rdata is unchanged.
REQ-019 Responses arriving in IDLE, REQ, DONE or ERR SHALL be ignored.
REQ-020 cpu_stall SHALL equal (state=IDLE and cpu_req) or state=REQ or state=WAIT, combinationally; it SHALL be 0 in DONE and ERR.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE; a cpu_req held high afterwards starts a new access from IDLE.
REQ-022 ERR SHALL last exactly one cycle with cpu_err=1 and cpu_rdata=0, set err_sticky, and then go to IDLE.
REQ-023 A timeout counter SHALL clear on entry to REQ and increment in each REQ or WAIT cycle.
- When the counter reaches TIMEOUT_CYCLES, the block SHALL go to ERR on that edge and bus_req SHALL drop.
REQ-024 The counter SHALL be 8 bits wide or wider, and SHALL saturate rather than wrap.
REQ-025 Minimum latency SHALL be 3 stall cycles: request in IDLE, REQ with bus_ready, WAIT with bus_resp_valid, then DONE.
REQ-026 If bus_ready and bus_resp_valid are both 1 in REQ, bus_resp_valid SHALL be ignored and the block SHALL wait for a response in WAIT.
REQ-027 bus_addr, bus_wdata and bus_we SHALL stay stable from entry to REQ until return to IDLE.

Reset
REQ-028 On reset the block SHALL set the following, taking priority over all transitions:
- state IDLE
- bus_req=0, bus_addr=0, bus_wdata=0, bus_we=0
- cpu_rdata=0, cpu_err=0, err_sticky=0
- counter 0
REQ-029 Reset in REQ or WAIT SHALL abandon the access; bus_req SHALL be 0 in the following cycle, and a late bus_resp_valid SHALL be ignored.

Verification
REQ-030 Load: cpu_req=1, addr=0x100, we=0; bus_ready immediate; bus_rdata=0xCAFEBABE one cycle later.
- Required: 3 stall cycles, then cpu_rdata=0xCAFEBABE with stall=0.
REQ-031 Store: addr=0x204, wdata=0x12345678, we=1; bus_ready delayed 4 cycles.
- Required: bus_req high for 5 cycles with the bus_* fields stable; stall clears in DONE.
REQ-032 Misaligned: addr=0x103.
- Required: bus_req never asserted; cpu_err pulses for 1 cycle; err_sticky=1; cpu_rdata=0.
REQ-033 Timeout: TIMEOUT_CYCLES=8; bus_ready=1 and no response.
- Required: ERR 8 cycles after entering REQ; cpu_err pulses; stall=0.
REQ-034 Reset in WAIT, then bus_resp_valid=1 the next cycle.
- Required: state IDLE, cpu_rdata=0, stall=0, no DONE.
REQ-035 Back-to-back: cpu_req held high across two loads.
- Required: exactly one stall-low DONE cycle between the accesses; the second request starts in the following IDLE cycle.
